// File: rtl/tap_load_arbiter_if.sv
// Loader-side bundle: HPS ioctl download channel plus the shared RAM write port.
// The environment drives ioctl/cpu_busy (master); the arbiter answers with wait and RAM writes (slave).
interface tap_load_arbiter_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        cpu_busy;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, cpu_busy,
    input  ioctl_wait, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data, cpu_busy,
    output ioctl_wait, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/tap_load_arbiter.sv
// Parses a KC87 TAP download and writes its payload into RAM, yielding every cycle to the CPU.
// state  | meaning
// IDLE   | waiting for a TAP download to start
// HDR    | skipping the 16-byte tape header
// BNUM   | consuming the block number byte
// FHDR   | first block: capturing load/end/exec addresses
// DATA   | payload bytes, written while ram_addr <= end
// WRITE  | byte latched, waiting for a CPU-free RAM cycle
// FINISH | one cycle: report done or error, then IDLE
module tap_load_arbiter #(
  parameter int         HDR_LEN   = 16,
  parameter int         BLK_LEN   = 129,
  parameter logic [7:0] TAP_INDEX = 8'd1
) (
  input  logic               clk,
  input  logic               reset_n,
  tap_load_arbiter_if.slave  bus,
  output logic               load_active,
  output logic               load_done,
  output logic               load_err,
  output logic [15:0]        exec_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BNUM, S_FHDR, S_DATA, S_WRITE, S_FINISH
  } state_t;

  localparam logic [7:0] HDR_LAST  = 8'(HDR_LEN - 1);
  localparam logic [7:0] DATA_LAST = 8'(BLK_LEN - 2);

  state_t      state, state_nx;
  logic        dl_q, first_blk, reached_end, fall_pend, wait_q;
  logic [7:0]  cnt, pos, data_q;
  logic [15:0] load_a, end_a, exec_tmp, addr_q;
  logic        dl_fall, start, addr_ok, wr_go;

  assign dl_fall = dl_q & ~bus.ioctl_download;
  assign start   = bus.ioctl_download & ~dl_q & (bus.ioctl_index == TAP_INDEX);
  // cnt counts down, so the position within the data block is its complement
  assign pos     = DATA_LAST - cnt;
  assign addr_ok = (addr_q <= end_a);
  assign wr_go   = (state == S_WRITE) & ~bus.cpu_busy;

  assign bus.ram_we     = wr_go;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign bus.ioctl_wait = wait_q;
  assign load_active    = (state != S_IDLE);
  assign load_done      = (state == S_FINISH) & reached_end & ~load_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR:
        if (dl_fall) state_nx = S_FINISH;
        else if (bus.ioctl_wr && cnt == 8'd0) state_nx = S_BNUM;
      S_BNUM:
        if (dl_fall) state_nx = S_FINISH;
        else if (bus.ioctl_wr) state_nx = first_blk ? S_FHDR : S_DATA;
      S_FHDR:
        if (dl_fall) state_nx = S_FINISH;
        else if (bus.ioctl_wr && cnt == 8'd0)
          state_nx = (end_a < load_a) ? S_FINISH : S_BNUM;
      S_DATA:
        if (dl_fall) state_nx = S_FINISH;
        else if (bus.ioctl_wr) begin
          if (addr_ok)            state_nx = S_WRITE;
          else if (cnt == 8'd0)   state_nx = S_BNUM;
        end
      S_WRITE:
        if (!bus.cpu_busy) begin
          if (dl_fall || fall_pend) state_nx = S_FINISH;
          else                      state_nx = (cnt == 8'd0) ? S_BNUM : S_DATA;
        end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = state;
    endcase
    if (start) state_nx = S_HDR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      wait_q      <= 1'b0;
      cnt         <= 8'd0;
      first_blk   <= 1'b0;
      reached_end <= 1'b0;
      fall_pend   <= 1'b0;
      load_a      <= 16'd0;
      end_a       <= 16'd0;
      exec_tmp    <= 16'd0;
      addr_q      <= 16'd0;
      data_q      <= 8'd0;
      load_err    <= 1'b0;
      exec_addr   <= 16'd0;
    end else begin
      dl_q   <= bus.ioctl_download;
      wait_q <= (state_nx == S_WRITE);
      if (start) begin
        cnt         <= HDR_LAST;
        first_blk   <= 1'b1;
        reached_end <= 1'b0;
        fall_pend   <= 1'b0;
        addr_q      <= 16'd0;
        load_err    <= 1'b0;
      end else begin
        case (state)
          S_HDR:
            if (bus.ioctl_wr && cnt != 8'd0) cnt <= cnt - 8'd1;
          S_BNUM:
            if (bus.ioctl_wr) cnt <= DATA_LAST;
          S_FHDR:
            if (bus.ioctl_wr) begin
              case (pos)
                8'd17: load_a[7:0]    <= bus.ioctl_data;
                8'd18: load_a[15:8]   <= bus.ioctl_data;
                8'd19: end_a[7:0]     <= bus.ioctl_data;
                8'd20: end_a[15:8]    <= bus.ioctl_data;
                8'd21: exec_tmp[7:0]  <= bus.ioctl_data;
                8'd22: exec_tmp[15:8] <= bus.ioctl_data;
                default: ;
              endcase
              if (cnt == 8'd0) begin
                first_blk <= 1'b0;
                if (end_a < load_a) load_err <= 1'b1;
                else begin
                  addr_q    <= load_a;
                  exec_addr <= exec_tmp;
                end
              end else cnt <= cnt - 8'd1;
            end
          S_DATA:
            if (bus.ioctl_wr) begin
              if (addr_ok)           data_q <= bus.ioctl_data;
              else if (cnt != 8'd0)  cnt <= cnt - 8'd1;
            end
          S_WRITE: begin
            // a download end seen while stalled must survive until the write lands
            if (dl_fall) fall_pend <= 1'b1;
            if (!bus.cpu_busy) begin
              addr_q <= addr_q + 16'd1;
              if (addr_q == end_a) reached_end <= 1'b1;
              if (cnt != 8'd0) cnt <= cnt - 8'd1;
            end
          end
          S_FINISH: begin
            fall_pend <= 1'b0;
            if (!(reached_end && !load_err)) load_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tap_load_arbiter.sv
// Directed bench for tap_load_arbiter: a table of whole-file loads plus reset-during-write.
module tb_tap_load_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_active, load_done, load_err;
  logic [15:0] exec_addr;
  int          errors = 0;
  int          checks = 0;

  tap_load_arbiter_if bus ();

  tap_load_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .load_active (load_active),
    .load_done   (load_done),
    .load_err    (load_err),
    .exec_addr   (exec_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  idx;
    logic [15:0] load_a;
    logic [15:0] end_a;
    logic [15:0] exec_a;
    int          busy;
    int          n_pay;
    int          exp_we;
    int          exp_done;
    logic        exp_err;
    logic [15:0] exp_exec;
  } vec_t;

  vec_t vecs[6];

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          done_cnt = 0;
  int          wait_total = 0;
  int          run = 0;
  int          exp_run = 1;
  bit          chk_run = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ram_we) begin
      check("we_cpu_free", 32'(bus.cpu_busy), 32'd0);
      wa.push_back(bus.ram_addr);
      wd.push_back(bus.ram_data);
    end
    if (load_done) done_cnt++;
    if (bus.ioctl_wait) begin
      run++;
      wait_total++;
    end else begin
      if (run != 0 && chk_run) check("wait_run", run, exp_run);
      run = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int busy);
    int n;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_data = b;
    if (busy > 0) bus.cpu_busy = 1'b1;
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
    repeat (busy) begin @(posedge clk); #1; end
    bus.cpu_busy = 1'b0;
    n = 0;
    while (bus.ioctl_wait && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_bound: ioctl_wait still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic send_head(input logic [15:0] la, input logic [15:0] ea,
                           input logic [15:0] xa, input int busy);
    for (int i = 0; i < 16; i++) send_byte(8'(i), busy);
    send_byte(8'h01, busy);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = 8'h20;
      case (i)
        17: b = la[7:0];
        18: b = la[15:8];
        19: b = ea[7:0];
        20: b = ea[15:8];
        21: b = xa[7:0];
        22: b = xa[15:8];
        default: ;
      endcase
      send_byte(b, busy);
    end
  endtask

  task automatic run_vec(input vec_t v);
    wa.delete();
    wd.delete();
    done_cnt   = 0;
    wait_total = 0;
    exp_run    = v.busy + 1;
    bus.ioctl_index    = v.idx;
    bus.ioctl_download = 1'b1;
    @(posedge clk); #1;
    send_head(v.load_a, v.end_a, v.exec_a, v.busy);
    check({v.name, "_active"}, 32'(load_active), 32'(v.idx == 8'd1));
    if (v.idx == 8'd1) check({v.name, "_err_fhdr"}, 32'(load_err), 32'(v.end_a < v.load_a));
    send_byte(8'h02, v.busy);
    for (int i = 0; i < v.n_pay; i++) send_byte(8'hA0 + 8'(i), v.busy);
    bus.ioctl_download = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check({v.name, "_we_count"}, wa.size(), v.exp_we);
    for (int k = 0; k < v.exp_we; k++) begin
      if (k < wa.size()) begin
        check({v.name, "_we_addr"}, 32'(wa[k]), 32'(v.load_a + 16'(k)));
        check({v.name, "_we_data"}, 32'(wd[k]), 32'(8'hA0 + 8'(k)));
      end
    end
    check({v.name, "_done"}, done_cnt, v.exp_done);
    check({v.name, "_err"}, 32'(load_err), 32'(v.exp_err));
    check({v.name, "_active_end"}, 32'(load_active), 32'd0);
    check({v.name, "_exec"}, 32'(exec_addr), 32'(v.exec_a == v.exec_a ? v.exp_exec : 16'h0));
    check({v.name, "_wait_total"}, wait_total, v.exp_we * (v.busy + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_data     = 8'd0;
    bus.cpu_busy       = 1'b0;

    vecs[0] = '{"nominal",   8'd1, 16'h0300, 16'h0304, 16'h0300, 0,  96, 5, 1, 1'b0, 16'h0300};
    vecs[1] = '{"contend",   8'd1, 16'h0300, 16'h0304, 16'h0300, 7,  96, 5, 1, 1'b0, 16'h0300};
    vecs[2] = '{"truncated", 8'd1, 16'h0300, 16'h0304, 16'h0310, 0,   2, 2, 0, 1'b1, 16'h0310};
    vecs[3] = '{"bad_hdr",   8'd1, 16'h0200, 16'h0100, 16'h0555, 0,   5, 0, 0, 1'b1, 16'h0310};
    vecs[4] = '{"foreign",   8'd0, 16'h0300, 16'h0304, 16'h0777, 0, 154, 0, 0, 1'b1, 16'h0310};
    vecs[5] = '{"single",    8'd1, 16'h0400, 16'h0400, 16'h0402, 2,   3, 1, 1, 1'b0, 16'h0402};

    #2;
    check("rst_wait",   32'(bus.ioctl_wait), 32'd0);
    check("rst_we",     32'(bus.ram_we),     32'd0);
    check("rst_addr",   32'(bus.ram_addr),   32'd0);
    check("rst_data",   32'(bus.ram_data),   32'd0);
    check("rst_active", 32'(load_active),    32'd0);
    check("rst_done",   32'(load_done),      32'd0);
    check("rst_err",    32'(load_err),       32'd0);
    check("rst_exec",   32'(exec_addr),      32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset while a loader write is stalled behind the CPU
    chk_run = 1'b0;
    wa.delete();
    wd.delete();
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    @(posedge clk); #1;
    send_head(16'h0300, 16'h0304, 16'h0300, 0);
    send_byte(8'h02, 0);
    bus.cpu_busy   = 1'b1;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_data = 8'hA0;
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
    check("rstw_wait_pre", 32'(bus.ioctl_wait), 32'd1);
    @(posedge clk); #1;
    reset_n            = 1'b0;
    bus.cpu_busy       = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    check("rstw_wait",   32'(bus.ioctl_wait), 32'd0);
    check("rstw_we",     32'(bus.ram_we),     32'd0);
    check("rstw_active", 32'(load_active),    32'd0);
    check("rstw_addr",   32'(bus.ram_addr),   32'd0);
    check("rstw_exec",   32'(exec_addr),      32'd0);
    @(posedge clk); #1;
    check("rstw_no_we", wa.size(), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_run = 1'b1;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
